dispatch_lane_sequencer: RTL and testbench
==========================================

# dispatch_lane_sequencer

Sits directly downstream of the per-issue-slot dispatch elastic buffer and directly upstream of an execute unit that has fewer lanes than `NUM_THREADS`. It accepts one full-warp dispatch packet at a time and splits it into `NUM_THREADS/NUM_LANES` lane-wide packets, one packet per cycle. Blocks whose thread-mask slice is all zero are skipped, and the first and last packet of each warp are tagged so the execute unit can reassemble per-warp results.

## Interface
- `NUM_THREADS`, default 8: threads per warp; a power of two.
- `NUM_LANES`, default 2: execute lanes; a power of two that divides `NUM_THREADS`.
- `HDR_W`, default 64: width of the per-warp header (uuid, wis, op, mod, PC, rd, wb, last tid, …), passed through opaquely.
- `PAYLOAD_W`, default 96: width of the per-thread operand payload (rs1/rs2/rs3 data).
- Derived: `NUM_PKTS = NUM_THREADS/NUM_LANES` and `PID_W = max(1, clog2(NUM_PKTS))`.

Ports:
- `clk`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-low.
- `in_valid`, input, 1: a warp packet is offered.
- `in_ready`, output, 1: the warp packet is accepted when both `in_valid` and `in_ready` are high.
- `in_hdr`, input, `HDR_W`: warp header.
- `in_tmask`, input, `NUM_THREADS`: thread mask.
- `in_data`, input, `NUM_THREADS*PAYLOAD_W`: per-thread payload; thread t occupies bits `[t*PAYLOAD_W +: PAYLOAD_W]`.
- `out_valid`, output, 1: a lane packet is valid.
- `out_ready`, input, 1: the execute unit accepts the lane packet.
- `out_hdr`, output, `HDR_W`: copy of the warp header.
- `out_tmask`, output, `NUM_LANES`: slice of the thread mask for this block.
- `out_data`, output, `NUM_LANES*PAYLOAD_W`: slice of the payload for this block.
- `out_pid`, output, `PID_W`: index of this block.
- `out_sop`, output, 1: first packet of the warp.
- `out_eop`, output, 1: last packet of the warp.

## Operation
- **Storage:** a holding register for header, mask and payload, plus a two-state FSM with states IDLE and SEND.
- **Block mask:** `blk_nz[p] = |in_tmask[p*NUM_LANES +: NUM_LANES]`, computed for the held warp.
- **IDLE → SEND** on an input fire.
  - Capture the warp into the holding register.
  - Set the current pid to the lowest p with `blk_nz[p]` set.
  - Set `sop=1`.
- **All-zero tmask:** emit exactly one packet with pid=0, `out_tmask=0`, `sop=eop=1`. The warp is never dropped.
- **SEND:**
  - `out_valid=1`.
  - Outputs are driven from the holding register sliced at the current pid.
  - `eop=1` when no set `blk_nz` bit has an index greater than the current pid.
- **Output fire in SEND:**
  - When `eop=0`: pid advances to the next set `blk_nz` index above the current pid, and `sop` clears.
  - When `eop=1`: if `in_valid` is high, the next warp is captured in the same cycle and the block stays in SEND; otherwise it returns to IDLE.
- **`in_ready`:** equals `(state==IDLE) || (out_valid && out_ready && out_eop)`. It is forced to 0 while `reset` is low.
- **Back-pressure:** while `out_valid && !out_ready`, every out_* signal holds stable.
- **Pass-through case:** when `NUM_LANES==NUM_THREADS`, `out_pid=0` and `sop=eop=1` always; the block acts as a one-entry register stage.

## Timing
- **Reset values** (`reset` low, at the clock edge):
  - state=IDLE.
  - `out_valid=0`, `out_sop=0`, `out_eop=0`, `out_pid=0`.
  - `out_tmask=0`; `out_hdr` and `out_data` are don't-care, but the bench checks 0.
  - `in_ready=0` while `reset` is low, and 1 in the first cycle after release.
- **Reset mid-warp:** discards the held warp immediately. No partial packet appears after reset is released.
- **Latency:** input fire at cycle N gives `out_valid` at N+1, carrying the first non-empty block.
- **Throughput:** a warp with k non-empty blocks occupies exactly k output cycles when `out_ready` stays high. The next warp's first packet follows with no bubble.
- **Combinational paths:** `in_ready` depends combinationally on `out_ready`. No combinational path exists from in_* to out_*.

## Test plan
- **Full warp** (NUM_THREADS=8, NUM_LANES=2): `tmask=8'hFF` with `out_ready=1` → packets pid 0, 1, 2, 3 in 4 consecutive cycles. pid 0 has `sop=1`, pid 3 has `eop=1`, each `out_tmask=2'b11`. The output data slices match their thread indices.
- **Sparse mask:** `tmask=8'b1000_0001` → two packets: pid 0 (`tmask=2'b01`, `sop=1`, `eop=0`), then pid 3 (`tmask=2'b10`, `sop=0`, `eop=1`). Blocks 1 and 2 are skipped.
- **Single-block and empty masks:**
  - `tmask=8'b0011_0000` → one packet, pid 2, `tmask=2'b11`, `sop=eop=1`.
  - `tmask=0` → one packet, pid 0, `tmask=0`, `sop=eop=1`.
- **Back-pressure:** hold `out_ready=0` for 5 cycles during pid 1 of an `8'hFF` warp → all outputs are stable and `in_ready=0`. After release, pids 1, 2, 3 follow one per cycle.
- **Back-to-back warps:** `8'hFF` and then `8'h0F` offered continuously → the second warp is accepted in the cycle pid 3 fires. Its pid 0 follows immediately, 6 packets in total over 6 cycles.
- **Reset mid-warp:** drive `reset` low after pid 1 of an `8'hFF` warp → `out_valid=0` from the next edge. After release, `in_ready=1` and no stale packet is emitted.

Source files
------------

// File: rtl/dispatch_lane_sequencer.sv
// Splits one full-warp dispatch packet into lane-wide packets, one per cycle,
// skipping all-zero mask blocks and tagging the first/last packet of each warp.
module dispatch_lane_sequencer #(
  parameter  int NUM_THREADS = 8,
  parameter  int NUM_LANES   = 2,
  parameter  int HDR_W       = 64,
  parameter  int PAYLOAD_W   = 96,
  localparam int NUM_PKTS    = NUM_THREADS / NUM_LANES,
  localparam int PID_W       = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [HDR_W-1:0]                 in_hdr,
  input  logic [NUM_THREADS-1:0]           in_tmask,
  input  logic [NUM_THREADS*PAYLOAD_W-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [HDR_W-1:0]                 out_hdr,
  output logic [NUM_LANES-1:0]             out_tmask,
  output logic [NUM_LANES*PAYLOAD_W-1:0]   out_data,
  output logic [PID_W-1:0]                 out_pid,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic                             dbg_state
);

  // Handshake: a transfer happens on a rising clk edge where valid && ready are
  // both high; valid never depends on ready, and out_* hold while stalled.
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                             r_state;
  logic [HDR_W-1:0]                   r_hdr;
  logic [NUM_THREADS-1:0]             r_tmask;
  logic [NUM_THREADS*PAYLOAD_W-1:0]   r_data;
  logic [PID_W-1:0]                   r_pid;
  logic                               r_sop;

  logic [NUM_PKTS-1:0]                w_blk_nz;
  logic [NUM_PKTS-1:0]                w_in_nz;
  logic [PID_W-1:0]                   w_first_pid;
  logic [PID_W-1:0]                   w_next_pid;
  logic                               w_has_next;
  logic                               w_in_fire;
  logic [NUM_LANES-1:0]               w_tmask_slice;
  logic [NUM_LANES*PAYLOAD_W-1:0]     w_data_slice;

  always_comb begin
    w_blk_nz      = '0;
    w_in_nz       = '0;
    w_first_pid   = '0;
    w_next_pid    = '0;
    w_has_next    = 1'b0;
    w_tmask_slice = '0;
    w_data_slice  = '0;
    for (int p = 0; p < NUM_PKTS; p++) begin
      w_blk_nz[p] = |r_tmask[p*NUM_LANES +: NUM_LANES];
      w_in_nz[p]  = |in_tmask[p*NUM_LANES +: NUM_LANES];
    end
    // Descending scans leave the lowest qualifying index; an empty warp keeps pid 0.
    for (int p = NUM_PKTS-1; p >= 0; p--) begin
      if (w_in_nz[p]) w_first_pid = PID_W'(p);
      if (w_blk_nz[p] && (PID_W'(p) > r_pid)) begin
        w_has_next = 1'b1;
        w_next_pid = PID_W'(p);
      end
    end
    for (int p = 0; p < NUM_PKTS; p++) begin
      if (PID_W'(p) == r_pid) begin
        w_tmask_slice = r_tmask[p*NUM_LANES +: NUM_LANES];
        w_data_slice  = r_data[p*NUM_LANES*PAYLOAD_W +: NUM_LANES*PAYLOAD_W];
      end
    end
  end

  assign out_valid = (r_state == SEND);
  assign out_hdr   = r_hdr;
  assign out_tmask = w_tmask_slice;
  assign out_data  = w_data_slice;
  assign out_pid   = r_pid;
  assign out_sop   = out_valid & r_sop;
  assign out_eop   = out_valid & ~w_has_next;
  assign in_ready  = reset & (~out_valid | (out_ready & out_eop));
  assign w_in_fire = in_valid & in_ready;
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_hdr   <= '0;
      r_tmask <= '0;
      r_data  <= '0;
      r_pid   <= '0;
      r_sop   <= 1'b0;
    end else if (w_in_fire) begin
      // Covers both IDLE capture and the back-to-back capture on the last packet.
      r_state <= SEND;
      r_hdr   <= in_hdr;
      r_tmask <= in_tmask;
      r_data  <= in_data;
      r_pid   <= w_first_pid;
      r_sop   <= 1'b1;
    end else if (r_state == SEND && out_ready) begin
      if (w_has_next) begin
        r_pid <= w_next_pid;
        r_sop <= 1'b0;
      end else begin
        r_state <= IDLE;
        r_pid   <= '0;
        r_sop   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_lane_sequencer.sv
// Directed bench for dispatch_lane_sequencer (8 threads, 2 lanes): expected
// packets are queued per scenario and compared cycle by cycle.
module tb_dispatch_lane_sequencer;

  localparam int NT = 8;
  localparam int NL = 2;
  localparam int HW = 64;
  localparam int PW = 96;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [HW-1:0]    in_hdr;
  logic [NT-1:0]    in_tmask;
  logic [NT*PW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [HW-1:0]    out_hdr;
  logic [NL-1:0]    out_tmask;
  logic [NL*PW-1:0] out_data;
  logic [1:0]       out_pid;
  logic             out_sop;
  logic             out_eop;
  logic             dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  // entry = {seed[7:0], pid[1:0], sop, eop, tmask[1:0]}
  logic [13:0] exp_q[$];

  dispatch_lane_sequencer #(
    .NUM_THREADS(NT), .NUM_LANES(NL), .HDR_W(HW), .PAYLOAD_W(PW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_hdr(in_hdr), .in_tmask(in_tmask), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hdr(out_hdr), .out_tmask(out_tmask), .out_data(out_data),
    .out_pid(out_pid), .out_sop(out_sop), .out_eop(out_eop),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] thr(input logic [7:0] s, input int t);
    return {s, 8'(t), 80'hDEAD_BEEF_0000_1111_2222};
  endfunction

  function automatic logic [HW-1:0] mk_hdr(input logic [7:0] s);
    return {s, 48'h1234_5678_9ABC, s};
  endfunction

  task automatic push(input logic [7:0] s, input logic [1:0] p, input logic so,
                      input logic eo, input logic [1:0] tm);
    exp_q.push_back({s, p, so, eo, tm});
  endtask

  // driver: present a warp (sampled at the next edge)
  task automatic present(input logic [7:0] tm, input logic [7:0] s);
    in_valid = 1'b1;
    in_tmask = tm;
    in_hdr   = mk_hdr(s);
    for (int t = 0; t < NT; t++) in_data[t*PW +: PW] = thr(s, t);
  endtask

  task automatic fire_warp(input logic [7:0] tm, input logic [7:0] s);
    present(tm, s);
    out_ready = 1'b1;
    check("in_ready_idle", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // scoreboard: one queued packet per output cycle, no bubbles allowed
  task automatic collect();
    logic [13:0] e;
    logic [7:0]  s;
    logic [1:0]  p;
    logic        so, eo;
    logic [1:0]  tm;
    out_ready = 1'b1;
    for (int i = 0; i < 16 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      {s, p, so, eo, tm} = e;
      check("out_valid", out_valid, 1'b1);
      check("out_pid", out_pid, p);
      check("out_sop", out_sop, so);
      check("out_eop", out_eop, eo);
      check("out_tmask", out_tmask, tm);
      check("out_hdr", out_hdr, mk_hdr(s));
      check("out_data", out_data, {thr(s, 2*p+1), thr(s, 2*p)});
      check("in_ready_send", in_ready, eo);
      @(posedge clk); #1;
      if (eo) begin
        if (in_valid) in_valid = 1'b0;
        else check("idle_after", out_valid, 1'b0);
      end
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_hdr = '0; in_tmask = '0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_sop", out_sop, 1'b0);
    check("rst_eop", out_eop, 1'b0);
    check("rst_pid", out_pid, 2'd0);
    check("rst_tmask", out_tmask, 2'b00);
    check("rst_hdr", out_hdr, 64'd0);
    check("rst_data", out_data, 192'd0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_state", dbg_state, 1'b0);
    reset = 1'b1; #1;
    check("rel_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // full warp
    push(8'h11, 2'd0, 1, 0, 2'b11); push(8'h11, 2'd1, 0, 0, 2'b11);
    push(8'h11, 2'd2, 0, 0, 2'b11); push(8'h11, 2'd3, 0, 1, 2'b11);
    fire_warp(8'hFF, 8'h11); collect();

    // sparse
    push(8'h22, 2'd0, 1, 0, 2'b01); push(8'h22, 2'd3, 0, 1, 2'b10);
    fire_warp(8'b1000_0001, 8'h22); collect();

    // single block, then empty
    push(8'h33, 2'd2, 1, 1, 2'b11);
    fire_warp(8'b0011_0000, 8'h33); collect();
    push(8'h44, 2'd0, 1, 1, 2'b00);
    fire_warp(8'h00, 8'h44); collect();

    // back-pressure during pid 1
    push(8'h55, 2'd0, 1, 0, 2'b11);
    fire_warp(8'hFF, 8'h55); collect();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1'b1);
      check("bp_pid", out_pid, 2'd1);
      check("bp_sop", out_sop, 1'b0);
      check("bp_eop", out_eop, 1'b0);
      check("bp_tmask", out_tmask, 2'b11);
      check("bp_data", out_data, {thr(8'h55, 3), thr(8'h55, 2)});
      check("bp_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    push(8'h55, 2'd1, 0, 0, 2'b11); push(8'h55, 2'd2, 0, 0, 2'b11);
    push(8'h55, 2'd3, 0, 1, 2'b11);
    collect();

    // back-to-back: second warp accepted on the edge pid 3 fires
    push(8'h66, 2'd0, 1, 0, 2'b11); push(8'h66, 2'd1, 0, 0, 2'b11);
    push(8'h66, 2'd2, 0, 0, 2'b11); push(8'h66, 2'd3, 0, 1, 2'b11);
    push(8'h77, 2'd0, 1, 0, 2'b11); push(8'h77, 2'd1, 0, 1, 2'b11);
    present(8'hFF, 8'h66);
    out_ready = 1'b1;
    @(posedge clk); #1;
    present(8'h0F, 8'h77);
    collect();

    // reset mid-warp after pid 1
    push(8'h88, 2'd0, 1, 0, 2'b11); push(8'h88, 2'd1, 0, 0, 2'b11);
    fire_warp(8'hFF, 8'h88); collect();
    reset = 1'b0; #1;
    check("mid_rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_pid", out_pid, 2'd0);
    check("mid_rst_tmask", out_tmask, 2'b00);
    reset = 1'b1; #1;
    check("mid_rel_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_stale", out_valid, 1'b0);
    end
    push(8'h99, 2'd1, 1, 0, 2'b10); push(8'h99, 2'd3, 0, 1, 2'b01);
    fire_warp(8'b0100_1000, 8'h99); collect();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
